// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// FSM state encoding, per-register control pair and counter sizing helper.
package pipeline_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MULDIV   = 2'd1,
      REDIRECT = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic enable;
      logic clear;
   } stage_ctrl_t;

   // Mul/div occupancy counter never narrower than 2 bits.
   function automatic int muldiv_cnt_w(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 2) ? 2 : w;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags an ID source that matches the
// destination of a load sitting in EX (x0 never creates a dependency).
import pipeline_pkg::*;

module hazard_detect (
   input  logic [REG_IDX_W-1:0] d_rs1_i,
   input  logic [REG_IDX_W-1:0] d_rs2_i,
   input  logic                 d_use_rs1_i,
   input  logic                 d_use_rs2_i,
   input  logic                 e_valid_i,
   input  logic [REG_IDX_W-1:0] e_rd_i,
   input  logic                 e_is_load_i,
   output logic                 load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit    = d_use_rs1_i && (d_rs1_i == e_rd_i);
   assign rs2_hit    = d_use_rs2_i && (d_rs2_i == e_rd_i);
   assign load_use_o = e_valid_i && e_is_load_i && (e_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline (stall/flush/muldiv).
// Optional performance counters enabled by defining PIPE_PERF_COUNTERS_EN.
import pipeline_pkg::*;

module pipeline_controller #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] d_rs1,
   input  logic [REG_IDX_W-1:0] d_rs2,
   input  logic                 d_use_rs1,
   input  logic                 d_use_rs2,
   input  logic                 e_valid,
   input  logic [REG_IDX_W-1:0] e_rd,
   input  logic                 e_is_load,
   input  logic                 e_is_muldiv,
   input  logic                 e_branch_taken,
   input  logic                 imem_stall,
   input  logic                 dmem_stall,
   output logic                 pc_enable,
   output logic                 fd_enable,
   output logic                 fd_clear,
   output logic                 de_enable,
   output logic                 de_clear,
   output logic                 em_enable,
   output logic                 em_clear,
   output logic                 muldiv_done,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          flush_count
);

   localparam int CNT_W   = muldiv_cnt_w(MULDIV_CYCLES);
   localparam bit MD_MULTI = (MULDIV_CYCLES > 1);
   localparam int MD_LOAD = MD_MULTI ? (MULDIV_CYCLES - 2) : 0;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LOAD);

   pipe_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use;
   logic             muldiv_hit;
   logic             pc_en;
   logic             done;
   stage_ctrl_t      fd_c, de_c, em_c;

   hazard_detect u_hazard (
      .d_rs1_i     (d_rs1),
      .d_rs2_i     (d_rs2),
      .d_use_rs1_i (d_use_rs1),
      .d_use_rs2_i (d_use_rs2),
      .e_valid_i   (e_valid),
      .e_rd_i      (e_rd),
      .e_is_load_i (e_is_load),
      .load_use_o  (load_use)
   );

   assign muldiv_hit = e_valid && e_is_muldiv;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A data-memory stall freezes sequencing in every state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!dmem_stall) begin
         unique case (state_q)
            RUN: begin
               if (e_branch_taken) begin
                  if (imem_stall) state_d = REDIRECT;
               end else if (muldiv_hit && MD_MULTI) begin
                  cnt_d   = CNT_LOAD;
                  state_d = MULDIV;
               end
            end
            MULDIV: begin
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            REDIRECT: begin
               if (!imem_stall) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      pc_en = 1'b1;
      fd_c  = '{enable: 1'b1, clear: 1'b0};
      de_c  = '{enable: 1'b1, clear: 1'b0};
      em_c  = '{enable: 1'b1, clear: 1'b0};
      done  = 1'b0;
      if (reset) begin
         pc_en = 1'b0;
         fd_c  = '{enable: 1'b0, clear: 1'b1};
         de_c  = '{enable: 1'b0, clear: 1'b1};
         em_c  = '{enable: 1'b0, clear: 1'b1};
      end else if (dmem_stall) begin
         pc_en = 1'b0;
         fd_c  = '{enable: 1'b0, clear: 1'b0};
         de_c  = '{enable: 1'b0, clear: 1'b0};
         em_c  = '{enable: 1'b0, clear: 1'b0};
      end else begin
         unique case (state_q)
            RUN: begin
               if (e_branch_taken) begin
                  fd_c = '{enable: 1'b0, clear: 1'b1};
                  de_c = '{enable: 1'b0, clear: 1'b1};
               end else if (muldiv_hit && MD_MULTI) begin
                  pc_en = 1'b0;
                  fd_c  = '{enable: 1'b0, clear: 1'b0};
                  de_c  = '{enable: 1'b0, clear: 1'b0};
                  em_c  = '{enable: 1'b0, clear: 1'b1};
               end else begin
                  // Single-cycle mul/div completes here without leaving RUN.
                  done = muldiv_hit && !MD_MULTI;
                  if (load_use || imem_stall) begin
                     pc_en = 1'b0;
                     fd_c  = '{enable: 1'b0, clear: 1'b0};
                     de_c  = '{enable: 1'b0, clear: 1'b1};
                  end
               end
            end
            MULDIV: begin
               if (cnt_q == '0) begin
                  done = 1'b1;
               end else begin
                  pc_en = 1'b0;
                  fd_c  = '{enable: 1'b0, clear: 1'b0};
                  de_c  = '{enable: 1'b0, clear: 1'b0};
                  em_c  = '{enable: 1'b0, clear: 1'b1};
               end
            end
            REDIRECT: begin
               pc_en = !imem_stall;
               fd_c  = '{enable: 1'b0, clear: 1'b1};
               de_c  = '{enable: 1'b0, clear: 1'b1};
            end
            default: begin
               pc_en = 1'b0;
            end
         endcase
      end
   end

   assign pc_enable   = pc_en;
   assign fd_enable   = fd_c.enable;
   assign fd_clear    = fd_c.clear;
   assign de_enable   = de_c.enable;
   assign de_clear    = de_c.clear;
   assign em_enable   = em_c.enable;
   assign em_clear    = em_c.clear;
   assign muldiv_done = done;

`ifdef PIPE_PERF_COUNTERS_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en)     stall_q <= stall_q + 32'd1;
         if (fd_c.clear) flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
